// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, word size and divider limits for the SPI master.
package spi_pkg;
  typedef enum logic [1:0] {SPI_IDLE, SPI_LOW, SPI_HIGH} spi_state_e;
  localparam int SPI_BITS = 8;
  localparam int CLK_DIV_MIN = 2;
  localparam int CLK_DIV_MAX = 255;
endpackage

// File: rtl/spi_clkdiv.sv
// spi_clkdiv: SCLK half-period counter; tick marks the last cycle of each half-period.
module spi_clkdiv
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 12
) (
  input  logic clock,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  logic [7:0] cnt;
  assign tick = cnt == 8'(CLK_DIV - 1);
  always_ff @(posedge clock or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 8'd1;
endmodule

// File: rtl/spi_master.sv
// spi_master: byte-wide mode-0 SPI master, MSB first, start/busy/done handshake.
// Define SPI_MASTER_LOOPBACK_EN to sample mosi instead of miso for board self-test.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 12
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       cs_keep,
  input  logic       cs_release,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);
  localparam int BW = $clog2(SPI_BITS);
  spi_state_e state, state_d;
  logic [SPI_BITS-1:0] shift, shift_d, rx_d;
  logic [BW-1:0] bit_cnt, bit_d;
  logic mosi_d, sclk_d, cs_n_d, done_d, keep, keep_d, tick, sample;
`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample = mosi;
`else
  assign sample = miso;
`endif
  assign busy = state != SPI_IDLE;
  // idle holds the divider cleared so LOW always starts a full half-period
  spi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clock(clock),
    .rst  (rst),
    .clr  (state == SPI_IDLE),
    .tick (tick)
  );
  always_comb begin
    state_d = state;
    shift_d = shift;
    bit_d   = bit_cnt;
    mosi_d  = mosi;
    sclk_d  = sclk;
    cs_n_d  = cs_n;
    done_d  = 1'b0;
    rx_d    = rx_data;
    keep_d  = keep;
    case (state)
      SPI_IDLE:
        if (start) begin
          state_d = SPI_LOW;
          shift_d = tx_data;
          keep_d  = cs_keep;
          cs_n_d  = 1'b0;
          mosi_d  = tx_data[SPI_BITS-1];
          bit_d   = BW'(SPI_BITS - 1);
        end else if (cs_release) cs_n_d = 1'b1;
      SPI_LOW:
        if (tick) begin
          shift_d = {shift[SPI_BITS-2:0], sample};
          sclk_d  = 1'b1;
          state_d = SPI_HIGH;
        end
      SPI_HIGH:
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_cnt == '0) begin
            state_d = SPI_IDLE;
            done_d  = 1'b1;
            rx_d    = shift;
            cs_n_d  = !keep;
          end else begin
            bit_d   = bit_cnt - 1'b1;
            mosi_d  = shift[SPI_BITS-1];
            state_d = SPI_LOW;
          end
        end
      default: state_d = SPI_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      state   <= SPI_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      mosi    <= 1'b0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      done    <= 1'b0;
      rx_data <= '0;
      keep    <= 1'b0;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      bit_cnt <= bit_d;
      mosi    <= mosi_d;
      sclk    <= sclk_d;
      cs_n    <= cs_n_d;
      done    <= done_d;
      rx_data <= rx_d;
      keep    <= keep_d;
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench; stimulus pushes expected bytes, a done monitor pops and compares.
module tb_spi_master;
  localparam int DIV = 2;
  logic clock = 0, rst = 1, start = 0, cs_keep = 0, cs_release = 0;
  logic [7:0] tx_data = 0;
  logic busy, done, sclk, mosi, cs_n, miso;
  logic [7:0] rx_data;
  spi_master #(.CLK_DIV(DIV)) dut (
    .clock(clock), .rst(rst), .start(start), .tx_data(tx_data), .cs_keep(cs_keep),
    .cs_release(cs_release), .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );
  always #5 clock = ~clock;
  typedef struct {logic [7:0] rx; int at;} exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int vectors = 0, miscompares = 0, cyc = 0, done_cnt = 0, cs_hi = 0;
  logic [7:0] slave_byte = 0;
  logic [2:0] sidx = 3'd7;
  logic mosi_bits[$];
  assign miso = slave_byte[sidx];
  always @(negedge sclk or posedge cs_n) sidx <= cs_n ? 3'd7 : sidx - 3'd1;
  always @(posedge sclk) mosi_bits.push_back(mosi);
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] sl);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return sl;
`endif
  endfunction
  always @(negedge clock)
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done at cycle %0d, expected none", cyc);
      end else begin
        e_mon = sb.pop_front();
        check("rx_data", rx_data, e_mon.rx);
        check("done_cycle", cyc, e_mon.at);
      end
    end
  task automatic issue(input logic [7:0] tx, input logic [7:0] sl, input logic keep,
                       input bit push, output int t);
    @(negedge clock);
    slave_byte = sl;
    tx_data = tx;
    cs_keep = keep;
    start = 1;
    t = cyc;
    if (push) sb.push_back('{exp_rx(tx, sl), t + 16 * DIV + 1});
    @(negedge clock);
    start = 0;
  endtask
  task automatic wait_done(input string name);
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clock);
      if (cs_n) cs_hi++;
      if (done) break;
    end
    if (n == 100) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no done within 100 cycles", name);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, viol, dc0;
    logic [7:0] mb;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rx_data, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 1);
    rst = 0;
    viol = 0;
    repeat (50) begin
      @(negedge clock);
      if (cs_n !== 1 || sclk !== 0 || busy !== 0 || done !== 0) viol++;
    end
    check("idle_50", viol, 0);
    mosi_bits.delete();
    issue(8'hA5, 8'h3C, 0, 1, t);
    check("accept_busy", busy, 1);
    check("accept_cs_n", cs_n, 0);
    check("accept_mosi", mosi, 1);
    @(negedge clock);
    check("sclk_before_rise", sclk, 0);
    @(negedge clock);
    check("first_sclk_rise", sclk, 1);
    wait_done("a5");
    check("busy_at_done", busy, 0);
    @(negedge clock);
    check("cs_n_after_done", cs_n, 1);
    check("done_one_cycle", done, 0);
    check("mosi_bit_count", mosi_bits.size(), 8);
    mb = 0;
    foreach (mosi_bits[i]) mb = {mb[6:0], mosi_bits[i]};
    check("mosi_bits", mb, 8'hA5);
    cs_hi = 0;
    issue(8'h40, 8'h5C, 1, 1, t);
    wait_done("keep1");
    issue(8'h00, 8'hE1, 1, 1, t);
    wait_done("keep2");
    check("keep_cs_low", cs_hi, 0);
    @(negedge clock);
    check("keep_cs_hold", cs_n, 0);
    cs_release = 1;
    @(negedge clock);
    cs_release = 0;
    check("cs_release", cs_n, 1);
    @(negedge clock);
    slave_byte = 8'hC3;
    tx_data = 8'h96;
    cs_keep = 0;
    start = 1;
    t = cyc;
    dc0 = done_cnt;
    for (int k = 1; k <= 3; k++) sb.push_back('{exp_rx(8'h96, 8'hC3), t + k * (16 * DIV + 1)});
    repeat (3 * 16 * DIV + 1) @(negedge clock);
    start = 0;
    repeat (16 * DIV + 8) @(negedge clock);
    check("held_start_dones", done_cnt - dc0, 3);
    check("held_start_idle", busy, 0);
    issue(8'h33, 8'h77, 0, 0, t);
    repeat (3 * 2 * DIV + 1) @(negedge clock);
    dc0 = done_cnt;
    rst = 1;
    #1;
    check("abort_cs_n", cs_n, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_rx", rx_data, 0);
    @(negedge clock);
    rst = 0;
    repeat (40) @(negedge clock);
    check("abort_no_done", done_cnt - dc0, 0);
    issue(8'hC9, 8'h6E, 0, 1, t);
    wait_done("after_abort");
    issue(8'h5A, 8'h00, 0, 1, t);
    wait_done("loopback");
    repeat (3) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
